nco_sequencer: RTL and testbench

Programmable step sequencer sitting directly upstream of the NCO: it stores a short pattern of note steps and, when started, plays them in order by pulsing the NCO's frequency-load and control-load inputs. Each step gives an 8-bit phase increment, a waveform select, a volume shift and a duration. At stop or pattern end it mutes the NCO (waveform 0). Pattern memory is written through a simple synchronous write port by the host/top level.

---
 rtl/nco_seq_pkg.sv | 36 +++
 rtl/nco_sequencer_if.sv | 33 +++
 rtl/step_ram.sv | 28 ++
 rtl/nco_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_nco_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/nco_seq_pkg.sv
// Shared definitions for the NCO step sequencer: FSM encoding, step-word layout
// and the control-word packing used for the NCO control-load port.
package nco_seq_pkg;

  localparam int STEP_W   = 22;
  localparam int FREQ_LSB = 14;
  localparam int FREQ_W   = 8;
  localparam int WAVE_LSB = 12;
  localparam int WAVE_W   = 2;
  localparam int VOL_LSB  = 8;
  localparam int VOL_W    = 4;
  localparam int DUR_LSB  = 0;
  localparam int DUR_W    = 8;

  localparam logic [WAVE_W-1:0] WAVE_OFF = 2'd0;
  localparam logic [VOL_W-1:0]  VOL_OFF  = 4'd0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_MUTE  = 2'd3;

  // Field order mirrors the bit layout of the step word, MSB first.
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [WAVE_W-1:0] wave;
    logic [VOL_W-1:0]  vol;
    logic [DUR_W-1:0]  dur;
  } step_t;

  function automatic logic [7:0] ctrl_word(input logic [VOL_W-1:0] vol,
                                           input logic [WAVE_W-1:0] wave);
    return {2'b00, vol, wave};
  endfunction

endpackage

// File: rtl/nco_sequencer_if.sv
// Host-facing bundle of the step sequencer: pattern write port, playback
// controls and the NCO load strobes/status it produces.
interface nco_sequencer_if #(
  parameter int ADDR_W = 4
);
  import nco_seq_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [STEP_W-1:0] wr_data;
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] last_step;
  logic              m_load;
  logic [7:0]        m_value;
  logic              ctrl_load;
  logic [7:0]        ctrl_value;
  logic              busy;
  logic [ADDR_W-1:0] step_idx;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop, last_step,
    input  m_load, m_value, ctrl_load, ctrl_value, busy, step_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop, last_step,
    output m_load, m_value, ctrl_load, ctrl_value, busy, step_idx, done
  );

endinterface

// File: rtl/step_ram.sv
// Pattern memory: DEPTH step words, synchronous write, combinational read.
// Deliberately left unreset; contents are undefined until the host writes them.
module step_ram
  import nco_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [STEP_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [STEP_W-1:0] rd_data
);

  logic [STEP_W-1:0] mem_r [DEPTH];

  // Host write port.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/nco_sequencer.sv
// Step sequencer driving the NCO load ports: plays stored steps in order,
// holding each for dur*TICK_DIV cycles, and mutes the NCO on stop or pattern end.
module nco_sequencer
  import nco_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 256
) (
  input  logic           clk,
  input  logic           reset,
  nco_sequencer_if.slave bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] IDX_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ZERO = {PRE_W{1'b0}};

  logic [1:0]        state_r;
  logic [1:0]        next_state_s;
  logic [1:0]        decide_state_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] next_idx_s;
  logic [ADDR_W-1:0] decide_idx_s;
  logic [ADDR_W-1:0] idx_inc_s;
  logic [PRE_W-1:0]  pre_r;
  logic [DUR_W-1:0]  hold_r;
  logic [STEP_W-1:0] rd_data_s;
  step_t             step_s;
  logic              pre_wrap_s;
  logic              hold_done_s;

  logic              m_load_r;
  logic [7:0]        m_value_r;
  logic              ctrl_load_r;
  logic [7:0]        ctrl_value_r;
  logic              busy_r;
  logic [ADDR_W-1:0] step_idx_r;
  logic              done_r;

  step_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_step_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx_r),
    .rd_data (rd_data_s)
  );

  assign step_s      = step_t'(rd_data_s);
  assign idx_inc_s   = (idx_r == IDX_MAX) ? IDX_ZERO : idx_r + ADDR_W'(1);
  assign pre_wrap_s  = (pre_r == PRE_MAX);
  assign hold_done_s = pre_wrap_s && (hold_r == DUR_W'(1));

  // Where to go once the current step has run its full duration.
  always_comb begin
    decide_state_s = ST_MUTE;
    decide_idx_s   = IDX_ZERO;
    if (idx_r != bus.last_step) begin
      decide_state_s = ST_ISSUE;
      decide_idx_s   = idx_inc_s;
    end else if (bus.loop) begin
      decide_state_s = ST_ISSUE;
      decide_idx_s   = IDX_ZERO;
    end else begin
      decide_state_s = ST_MUTE;
      decide_idx_s   = IDX_ZERO;
    end
  end

  // Playback FSM; stop outranks everything while a pattern is running.
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          next_state_s = ST_ISSUE;
          next_idx_s   = IDX_ZERO;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.stop) begin
          next_state_s = ST_MUTE;
        end else if (step_s.dur == DUR_W'(0)) begin
          next_state_s = decide_state_s;
          next_idx_s   = decide_idx_s;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.stop) begin
          next_state_s = ST_MUTE;
        end else if (hold_done_s) begin
          next_state_s = decide_state_s;
          next_idx_s   = decide_idx_s;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_MUTE: begin
        next_state_s = ST_IDLE;
        next_idx_s   = IDX_ZERO;
      end
      default: begin
        next_state_s = ST_IDLE;
        next_idx_s   = IDX_ZERO;
      end
    endcase
  end

  // State, step index, prescaler and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_ZERO;
      pre_r   <= PRE_ZERO;
      hold_r  <= DUR_W'(0);
    end else begin
      state_r <= next_state_s;
      idx_r   <= next_idx_s;
      case (state_r)
        ST_ISSUE: begin
          hold_r <= step_s.dur;
          pre_r  <= PRE_ZERO;
        end
        ST_HOLD: begin
          if (pre_wrap_s) begin
            pre_r  <= PRE_ZERO;
            hold_r <= hold_r - DUR_W'(1);
          end else begin
            pre_r <= pre_r + PRE_W'(1);
          end
        end
        default: begin
          pre_r  <= PRE_ZERO;
          hold_r <= DUR_W'(0);
        end
      endcase
    end
  end

  // Output registers: strobes appear the cycle after the state that issues them,
  // so a step captured here is immune to later writes of its slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_load_r     <= 1'b0;
      m_value_r    <= 8'd0;
      ctrl_load_r  <= 1'b0;
      ctrl_value_r <= 8'd0;
      busy_r       <= 1'b0;
      step_idx_r   <= IDX_ZERO;
      done_r       <= 1'b0;
    end else begin
      m_load_r    <= 1'b0;
      ctrl_load_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= (state_r == ST_ISSUE) || (state_r == ST_HOLD);
      case (state_r)
        ST_ISSUE: begin
          if (!bus.stop) begin
            m_load_r     <= 1'b1;
            m_value_r    <= step_s.freq;
            ctrl_load_r  <= 1'b1;
            ctrl_value_r <= ctrl_word(step_s.vol, step_s.wave);
            step_idx_r   <= idx_r;
          end
        end
        ST_MUTE: begin
          ctrl_load_r  <= 1'b1;
          ctrl_value_r <= ctrl_word(VOL_OFF, WAVE_OFF);
          done_r       <= 1'b1;
          step_idx_r   <= IDX_ZERO;
        end
        default: begin
          step_idx_r <= step_idx_r;
        end
      endcase
    end
  end

  assign bus.m_load     = m_load_r;
  assign bus.m_value    = m_value_r;
  assign bus.ctrl_load  = ctrl_load_r;
  assign bus.ctrl_value = ctrl_value_r;
  assign bus.busy       = busy_r;
  assign bus.step_idx   = step_idx_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_nco_sequencer.sv
// Directed bench for nco_sequencer with TICK_DIV=4: logs every control-load
// strobe with its cycle number and compares against hand-computed timelines.
module tb_nco_sequencer;

  typedef struct {
    int         cyc;
    logic       ml;
    logic [7:0] mv;
    logic [7:0] cv;
    logic [3:0] ix;
    logic       dn;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_cnt = 0;
  ev_t  log_q[$];

  nco_sequencer_if #(.ADDR_W(4)) bus();

  nco_sequencer #(
    .DEPTH    (16),
    .TICK_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ctrl_load) begin
      log_q.push_back('{cyc, bus.m_load, bus.m_value, bus.ctrl_value, bus.step_idx, bus.done});
    end
    if (bus.done) done_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_entry(input string tag, input int i, input int cyc_e, input logic ml,
                             input logic [7:0] mv, input logic [7:0] cv, input logic [3:0] ix,
                             input logic dn);
    check_value({tag, "_present"}, 32'(log_q.size() > i), 32'd1);
    if (log_q.size() > i) begin
      check_value({tag, "_cyc"}, 32'(log_q[i].cyc), 32'(cyc_e));
      check_value({tag, "_mload"}, 32'(log_q[i].ml), 32'(ml));
      if (ml) check_value({tag, "_mval"}, 32'(log_q[i].mv), 32'(mv));
      check_value({tag, "_cval"}, 32'(log_q[i].cv), 32'(cv));
      check_value({tag, "_idx"}, 32'(log_q[i].ix), 32'(ix));
      check_value({tag, "_done"}, 32'(log_q[i].dn), 32'(dn));
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_slot(input logic [3:0] a, input logic [7:0] f, input logic [1:0] w,
                            input logic [3:0] v, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = {f, w, v, d};
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic start_play(output int ts);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    ts = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_mload"}, 32'(bus.m_load), 32'd0);
    check_value({tag, "_mval"}, 32'(bus.m_value), 32'd0);
    check_value({tag, "_cload"}, 32'(bus.ctrl_load), 32'd0);
    check_value({tag, "_cval"}, 32'(bus.ctrl_value), 32'd0);
    check_value({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_value({tag, "_idx"}, 32'(bus.step_idx), 32'd0);
    check_value({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int ts;
    int d0;
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 4'd0;
    bus.wr_data   = 22'd0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.loop      = 1'b0;
    bus.last_step = 4'd0;
    #1;
    check_outputs_zero("reset");
    #20;
    reset = 1'b0;

    // Single step, dur=2: strobe pair then mute 9 cycles later.
    write_slot(4'd0, 8'd19, 2'd3, 4'd0, 8'd2);
    log_q.delete();
    d0 = done_cnt;
    start_play(ts);
    wait_until(ts + 20);
    check_entry("t1_issue", 0, ts + 2, 1'b1, 8'd19, 8'h03, 4'd0, 1'b0);
    check_entry("t1_mute", 1, ts + 11, 1'b0, 8'd0, 8'h00, 4'd0, 1'b1);
    check_value("t1_nlog", 32'(log_q.size()), 32'd2);
    check_value("t1_done", 32'(done_cnt - d0), 32'd1);
    check_value("t1_busy", 32'(bus.busy), 32'd0);

    // Three steps dur 1,0,3: spacing 5, 1, 13.
    write_slot(4'd0, 8'd10, 2'd1, 4'd5, 8'd1);
    write_slot(4'd1, 8'd20, 2'd2, 4'd6, 8'd0);
    write_slot(4'd2, 8'd30, 2'd0, 4'd7, 8'd3);
    bus.last_step = 4'd2;
    log_q.delete();
    start_play(ts);
    wait_until(ts + 30);
    check_entry("t2_s0", 0, ts + 2, 1'b1, 8'd10, 8'h15, 4'd0, 1'b0);
    check_entry("t2_s1", 1, ts + 7, 1'b1, 8'd20, 8'h1A, 4'd1, 1'b0);
    check_entry("t2_s2", 2, ts + 8, 1'b1, 8'd30, 8'h1C, 4'd2, 1'b0);
    check_entry("t2_mute", 3, ts + 21, 1'b0, 8'd0, 8'h00, 4'd0, 1'b1);
    check_value("t2_nlog", 32'(log_q.size()), 32'd4);

    // Looping two steps; rewrite slot0 while it is held, then drop loop.
    write_slot(4'd0, 8'd19, 2'd3, 4'd0, 8'd1);
    write_slot(4'd1, 8'd20, 2'd2, 4'd6, 8'd1);
    bus.last_step = 4'd1;
    bus.loop      = 1'b1;
    log_q.delete();
    d0 = done_cnt;
    start_play(ts);
    wait_until(ts + 14);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd0;
    bus.wr_data = {8'd40, 2'd3, 4'd0, 8'd1};
    wait_until(ts + 15);
    bus.wr_en = 1'b0;
    wait_until(ts + 24);
    check_value("t3_nodone_loop", 32'(done_cnt - d0), 32'd0);
    bus.loop = 1'b0;
    wait_until(ts + 40);
    check_entry("t3_p0s0", 0, ts + 2, 1'b1, 8'd19, 8'h03, 4'd0, 1'b0);
    check_entry("t3_p0s1", 1, ts + 7, 1'b1, 8'd20, 8'h1A, 4'd1, 1'b0);
    check_entry("t3_p1s0", 2, ts + 12, 1'b1, 8'd19, 8'h03, 4'd0, 1'b0);
    check_entry("t3_p1s1", 3, ts + 17, 1'b1, 8'd20, 8'h1A, 4'd1, 1'b0);
    check_entry("t3_p2s0", 4, ts + 22, 1'b1, 8'd40, 8'h03, 4'd0, 1'b0);
    check_entry("t3_p2s1", 5, ts + 27, 1'b1, 8'd20, 8'h1A, 4'd1, 1'b0);
    check_entry("t3_mute", 6, ts + 32, 1'b0, 8'd0, 8'h00, 4'd0, 1'b1);
    check_value("t3_nlog", 32'(log_q.size()), 32'd7);
    check_value("t3_done", 32'(done_cnt - d0), 32'd1);

    // Stop during the hold of step1.
    write_slot(4'd0, 8'd10, 2'd1, 4'd5, 8'd1);
    write_slot(4'd1, 8'd20, 2'd2, 4'd6, 8'd3);
    log_q.delete();
    d0 = done_cnt;
    start_play(ts);
    wait_until(ts + 9);
    bus.stop = 1'b1;
    wait_until(ts + 10);
    bus.stop = 1'b0;
    wait_until(ts + 30);
    check_entry("t4_s0", 0, ts + 2, 1'b1, 8'd10, 8'h15, 4'd0, 1'b0);
    check_entry("t4_s1", 1, ts + 7, 1'b1, 8'd20, 8'h1A, 4'd1, 1'b0);
    check_entry("t4_mute", 2, ts + 11, 1'b0, 8'd0, 8'h00, 4'd0, 1'b1);
    check_value("t4_nlog", 32'(log_q.size()), 32'd3);
    check_value("t4_done", 32'(done_cnt - d0), 32'd1);

    // start and stop together in IDLE: nothing happens.
    log_q.delete();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    wait_until(cyc + 1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    wait_until(cyc + 10);
    check_value("t5_nlog", 32'(log_q.size()), 32'd0);
    check_value("t5_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset in HOLD, then replay from step 0.
    start_play(ts);
    wait_until(ts + 9);
    check_value("t6_busy_pre", 32'(bus.busy), 32'd1);
    check_value("t6_idx_pre", 32'(bus.step_idx), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    log_q.delete();
    start_play(ts);
    wait_until(ts + 8);
    check_entry("t6_s0", 0, ts + 2, 1'b1, 8'd10, 8'h15, 4'd0, 1'b0);
    check_entry("t6_s1", 1, ts + 7, 1'b1, 8'd20, 8'h1A, 4'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
